// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared definitions for the 2-master AHB fabric:
//   - HTRANS encodings
//   - arbiter state encoding (PARK / OWN1 / OWN2)
//   - master index constants (M1 = master 1, M2 = master 2)
//   - htrans_active(): true for transfers that move data (NONSEQ / SEQ)
// ---------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;

    typedef enum logic [1:0] {
        PARK = 2'b00,
        OWN1 = 2'b01,
        OWN2 = 2'b10
    } arb_state_e;

    function automatic logic htrans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_rr_pick
// Combinational two-way round-robin chooser.
//   req[1:0]  in   request vector, bit0 = master 1, bit1 = master 2
//   last      in   index of the master that last won the bus
//   dflt      in   index returned when nobody requests
//   win       out  chosen master index
//   any       out  at least one request is pending
// ---------------------------------------------------------------------------
module ahb_rr_pick
    import ahb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       dflt,
    output logic       win,
    output logic       any
);

    // Lone requester wins outright; with contention the master that did not
    // win last time gets the bus.
    always_comb begin
        win = dflt;
        any = 1'b0;
        case (req)
            2'b01: begin
                win = M1;
                any = 1'b1;
            end
            2'b10: begin
                win = M2;
                any = 1'b1;
            end
            2'b11: begin
                win = ~last;
                any = 1'b1;
            end
            default: begin
                win = dflt;
                any = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_2m
// Round-robin bus arbiter for two AHB masters with a tenure cap.
// Optional feature macro: AHB_ARB_LOCK_EN (honour hlock_1 / hlock_2 locked
// sequences; when undefined the lock inputs are ignored, hmastlock is 0).
// Ports:
//   hclk, hresetn           clock, asynchronous active-low reset
//   hbusreq_1, hbusreq_2    bus requests
//   hlock_1, hlock_2        locked-sequence requests
//   htrans                  htrans of the current address-phase owner
//   hready                  transfer done
//   hgrant_1, hgrant_2      one-hot grants (registered)
//   hmaster                 address-phase owner (0 = m1, 1 = m2)
//   hmaster_d               data-phase owner, hwdata mux select
//   hmastlock               current address phase is locked
// ---------------------------------------------------------------------------
module ahb_arbiter_2m
    import ahb_pkg::*;
#(
    parameter int   MAX_HOLD       = 16,
    parameter logic DEFAULT_MASTER = 1'b0
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hbusreq_1,
    input  logic       hbusreq_2,
    input  logic       hlock_1,
    input  logic       hlock_2,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       hgrant_1,
    output logic       hgrant_2,
    output logic       hmaster,
    output logic       hmaster_d,
    output logic       hmastlock
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    arb_state_e       state_r,     state_nxt_s;
    logic             grant_r,     grant_nxt_s;
    logic             rr_last_r,   rr_last_nxt_s;
    logic [CNT_W-1:0] hold_cnt_r,  hold_cnt_nxt_s;
    logic             hmaster_r,   hmaster_nxt_s;
    logic             hmaster_d_r, hmaster_d_nxt_s;
    logic             hmastlock_r, hmastlock_nxt_s;

    logic [1:0] req_s;
    logic       owner_req_s;
    logic       other_req_s;
    logic       owner_lock_s;
    logic       beat_s;
    logic       cap_s;
    logic       release_s;
    logic       park_s;
    logic       arb_point_s;
    logic       pick_win_s;
    logic       pick_any_s;

    assign req_s       = {hbusreq_2, hbusreq_1};
    assign owner_req_s = grant_r ? hbusreq_2 : hbusreq_1;
    assign other_req_s = grant_r ? hbusreq_1 : hbusreq_2;

`ifdef AHB_ARB_LOCK_EN
    assign owner_lock_s = grant_r ? hlock_2 : hlock_1;
`else
    // Lock requests have no effect in this build; the AND keeps the inputs
    // referenced so the port list is identical in both builds.
    assign owner_lock_s = 1'b0 & (hlock_1 | hlock_2);
`endif

    assign beat_s    = hready & htrans_active(htrans);
    // Cap only bites when there is someone to hand over to.
    assign cap_s     = (hold_cnt_r == HOLD_LAST) & htrans_active(htrans) & other_req_s;
    assign release_s = ~owner_req_s | (htrans == HTRANS_IDLE) | cap_s;
    assign park_s    = (state_r == PARK);
    // A locked owner keeps the bus; only a parked grant re-arbitrates then.
    assign arb_point_s = hready & (park_s | (release_s & ~owner_lock_s));

    ahb_rr_pick u_pick (
        .req  (req_s),
        .last (rr_last_r),
        .dflt (DEFAULT_MASTER),
        .win  (pick_win_s),
        .any  (pick_any_s)
    );

    // Next-state, grant, round-robin history, tenure counter and phase owners.
    always_comb begin
        state_nxt_s     = state_r;
        grant_nxt_s     = grant_r;
        rr_last_nxt_s   = rr_last_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        hmaster_nxt_s   = hmaster_r;
        hmaster_d_nxt_s = hmaster_d_r;
        hmastlock_nxt_s = hmastlock_r;

        if (arb_point_s) begin
            grant_nxt_s = pick_win_s;
            if (!pick_any_s) begin
                state_nxt_s = PARK;
            end else if (pick_win_s == M2) begin
                state_nxt_s = OWN2;
            end else begin
                state_nxt_s = OWN1;
            end
        end else begin
            grant_nxt_s = grant_r;
            state_nxt_s = state_r;
        end

        if (arb_point_s && (pick_win_s != grant_r)) begin
            rr_last_nxt_s  = pick_win_s;
            hold_cnt_nxt_s = '0;
        end else if (beat_s && !owner_lock_s && (hold_cnt_r != HOLD_LAST)) begin
            hold_cnt_nxt_s = hold_cnt_r + CNT_ONE;
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end

        // Address and data phase owners advance only on completed transfers.
        if (hready) begin
            hmaster_nxt_s   = grant_r;
            hmaster_d_nxt_s = hmaster_r;
            hmastlock_nxt_s = owner_lock_s;
        end else begin
            hmaster_nxt_s   = hmaster_r;
            hmaster_d_nxt_s = hmaster_d_r;
            hmastlock_nxt_s = hmastlock_r;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= PARK;
            grant_r     <= DEFAULT_MASTER;
            rr_last_r   <= DEFAULT_MASTER;
            hold_cnt_r  <= '0;
            hmaster_r   <= DEFAULT_MASTER;
            hmaster_d_r <= DEFAULT_MASTER;
            hmastlock_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            rr_last_r   <= rr_last_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            hmaster_r   <= hmaster_nxt_s;
            hmaster_d_r <= hmaster_d_nxt_s;
            hmastlock_r <= hmastlock_nxt_s;
        end
    end

    assign hgrant_1  = ~grant_r;
    assign hgrant_2  = grant_r;
    assign hmaster   = hmaster_r;
    assign hmaster_d = hmaster_d_r;
    assign hmastlock = hmastlock_r;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_2m
// Scoreboard bench for ahb_arbiter_2m: the driver applies inputs on the
// falling edge, steps a behavioural model and queues the expected outputs;
// a monitor pops and compares after every rising edge and after every
// asynchronous reset assertion. Directed scenarios are followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_2m;
    import ahb_pkg::*;

    localparam int   MAX_HOLD = 16;
    localparam logic DFLT     = 1'b0;
`ifdef AHB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       hclk      = 1'b0;
    logic       hresetn   = 1'b0;
    logic       hbusreq_1 = 1'b0;
    logic       hbusreq_2 = 1'b0;
    logic       hlock_1   = 1'b0;
    logic       hlock_2   = 1'b0;
    logic [1:0] htrans    = 2'b00;
    logic       hready    = 1'b1;
    logic       hgrant_1, hgrant_2, hmaster, hmaster_d, hmastlock;

    ahb_arbiter_2m #(.MAX_HOLD(MAX_HOLD), .DEFAULT_MASTER(DFLT)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .hbusreq_1(hbusreq_1), .hbusreq_2(hbusreq_2),
        .hlock_1(hlock_1), .hlock_2(hlock_2),
        .htrans(htrans), .hready(hready),
        .hgrant_1(hgrant_1), .hgrant_2(hgrant_2),
        .hmaster(hmaster), .hmaster_d(hmaster_d), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic g1;
        logic g2;
        logic hm;
        logic hmd;
        logic ml;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    // Reference model: bus owner, parked flag, last winner, beat count.
    int m_owner;
    bit m_park;
    int m_last;
    int m_beats;
    int m_hm;
    int m_hmd;
    bit m_ml;

    function automatic void m_reset();
        m_owner = int'(DFLT);
        m_park  = 1'b1;
        m_last  = int'(DFLT);
        m_beats = 0;
        m_hm    = int'(DFLT);
        m_hmd   = int'(DFLT);
        m_ml    = 1'b0;
    endfunction

    function automatic void m_step(input bit r1, input bit r2, input bit l1, input bit l2,
                                   input logic [1:0] ht, input bit rdy);
        bit req[2];
        bit lk[2];
        bit locked, active, arb, moved;
        int other, nreq, win;
        if (!rdy) return;
        req[0] = r1; req[1] = r2;
        lk[0]  = l1; lk[1]  = l2;
        other  = 1 - m_owner;
        locked = LOCK_EN && lk[m_owner];
        active = (ht == 2'b10) || (ht == 2'b11);
        arb    = m_park ||
                 (!locked && (!req[m_owner] || ht == 2'b00 ||
                              (m_beats == MAX_HOLD - 1 && active && req[other])));
        m_hmd = m_hm;
        m_hm  = m_owner;
        m_ml  = locked;
        moved = 1'b0;
        if (arb) begin
            nreq = int'(req[0]) + int'(req[1]);
            if (nreq == 2)   win = 1 - m_last;
            else if (req[0]) win = 0;
            else if (req[1]) win = 1;
            else             win = int'(DFLT);
            m_park = (nreq == 0);
            if (win != m_owner) begin
                m_owner = win;
                m_last  = win;
                m_beats = 0;
                moved   = 1'b1;
            end
        end
        if (!moved && active && !locked && m_beats < MAX_HOLD - 1) m_beats++;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.g1  = (m_owner == 0);
        e.g2  = (m_owner == 1);
        e.hm  = (m_hm == 1);
        e.hmd = (m_hmd == 1);
        e.ml  = m_ml;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // One bus cycle: drive on the falling edge, queue the post-edge outputs.
    task automatic cyc(input bit r1, input bit r2, input bit l1, input bit l2,
                       input logic [1:0] ht, input bit rdy);
        @(negedge hclk);
        hresetn   = 1'b1;
        hbusreq_1 = r1;
        hbusreq_2 = r2;
        hlock_1   = l1;
        hlock_2   = l2;
        htrans    = ht;
        hready    = rdy;
        m_step(r1, r2, l1, l2, ht, rdy);
        push_exp();
    endtask

    // Assert reset for n rising edges; also queues the immediate async check.
    task automatic apply_reset(input int n);
        @(negedge hclk);
        m_reset();
        if (hresetn === 1'b1) begin
            push_exp();
            hresetn = 1'b0;
        end else begin
            hresetn = 1'b0;
        end
        mon_en = 1'b1;
        push_exp();
        for (int i = 1; i < n; i++) begin
            @(negedge hclk);
            push_exp();
        end
    endtask

    task automatic after_edge();
        @(posedge hclk);
        #1;
    endtask

    // Monitor: compare outputs against the oldest queued expectation.
    initial begin : monitor
        exp_t       e;
        logic [4:0] got;
        forever begin
            @(posedge hclk or negedge hresetn);
            #1;
            if (mon_en) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: no expectation queued at t=%0t", $time);
                end else begin
                    e   = exp_q.pop_front();
                    got = {hgrant_1, hgrant_2, hmaster, hmaster_d, hmastlock};
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL sb_outputs t=%0t {g1,g2,hm,hmd,ml}: got %b expected %b",
                                 $time, got, e);
                    end
                end
            end
        end
    end

    // Watchdog: the run is short; reaching this means something hung.
    initial begin : watchdog
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int  first_g2;
        int  ml_bad;
        int  wait_moves;
        bit  g2_before;
        bit  r1, r2, l1, l2;

        // Reset state.
        apply_reset(2);
        check("reset_hgrant_1", int'(hgrant_1), 1);
        check("reset_hgrant_2", int'(hgrant_2), 0);
        check("reset_hmaster", int'(hmaster), 0);
        check("reset_hmastlock", int'(hmastlock), 0);

        // Single request from master 2, then release back to park.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        after_edge();
        check("single_grant2", int'(hgrant_2), 1);
        check("single_hmaster_lag", int'(hmaster), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 1'b1);
        after_edge();
        check("single_hmaster", int'(hmaster), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        after_edge();
        check("release_park_grant1", int'(hgrant_1), 1);

        // Reset in the middle of a master 2 burst.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b1);
        apply_reset(2);
        check("midreset_hgrant_1", int'(hgrant_1), 1);
        check("midreset_hgrant_2", int'(hgrant_2), 0);
        check("midreset_hmaster", int'(hmaster), 0);
        check("midreset_hmaster_d", int'(hmaster_d), 0);

        // Contention from park: master 2 first, then strict alternation.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        after_edge();
        check("contend_first_m2", int'(hgrant_2), 1);
        for (int r = 0; r < 4; r++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 1'b1);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b1);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
            after_edge();
            check($sformatf("contend_round%0d_grant1", r), int'(hgrant_1), (r % 2 == 0) ? 1 : 0);
        end

        // Tenure cap: NONSEQ + SEQ beats from master 1, 5 wait states mid-burst.
        apply_reset(2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        first_g2   = -1;
        wait_moves = 0;
        for (int i = 0; i < 21 && first_g2 < 0; i++) begin
            if (i == 8) begin
                g2_before = hgrant_2;
                for (int w = 0; w < 5; w++) begin
                    cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b0);
                    after_edge();
                    if (hgrant_2 !== g2_before) wait_moves++;
                end
            end
            cyc(1'b1, 1'b1, 1'b0, 1'b0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
            after_edge();
            if (hgrant_2 === 1'b1) first_g2 = i + 1;
        end
        check("tenure_handover_beat", first_g2, MAX_HOLD);
        check("tenure_wait_no_change", wait_moves, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);

        // Data phase owner lags by one completed transfer across a handover.
        apply_reset(1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_NONSEQ, 1'b1);
        after_edge();
        check("dphase_hmaster", int'(hmaster), 1);
        check("dphase_hmaster_d_lag", int'(hmaster_d), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_SEQ, 1'b1);
        after_edge();
        check("dphase_hmaster_d", int'(hmaster_d), 1);

        // Locked sequence from master 1 for 30 beats with master 2 waiting.
        apply_reset(2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, HTRANS_IDLE, 1'b1);
        first_g2 = -1;
        ml_bad   = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
            after_edge();
            if (first_g2 < 0 && hgrant_2 === 1'b1) first_g2 = i + 1;
            if (hmastlock !== LOCK_EN) ml_bad++;
        end
        check("lock_handover_beat", first_g2, LOCK_EN ? -1 : MAX_HOLD);
        check("lock_hmastlock_beats", ml_bad, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);
        after_edge();
        check("lock_release_grant2", int'(hgrant_2), 1);

        // Randomized traffic, with occasional resets.
        r1 = 1'b0; r2 = 1'b0; l1 = 1'b0; l2 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset(1 + $urandom_range(0, 2));
            end else begin
                if ($urandom_range(0, 7) == 0)  r1 = ~r1;
                if ($urandom_range(0, 7) == 0)  r2 = ~r2;
                if ($urandom_range(0, 15) == 0) l1 = ~l1;
                if ($urandom_range(0, 15) == 0) l2 = ~l2;
                cyc(r1, r2, l1, l2, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 8));
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, HTRANS_IDLE, 1'b1);

        @(posedge hclk);
        #2;
        mon_en = 1'b0;
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
